// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared FSM states and tag helpers for the N-port AXI read arbiter
package axi_arb_pkg;
  typedef enum logic {IDLE, ISSUE} state_t;
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic int unsigned tag_of(input logic [31:0] id, input int id_w, input int tw);
    return (id >> (id_w - tw)) & ((32'd1 << tw) - 32'd1);
  endfunction
endpackage

// File: rtl/axi_rd_arbiter_n_if.sv
// axi_rd_arbiter_n_if: AR/R bus plus per-port request and return channels
interface axi_rd_arbiter_n_if
  import axi_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int AXI_ID_W = 8,
  parameter int ADDR_W = 33,
  parameter int LEN_W = 8,
  parameter int DATA_W = 256
);
  localparam int PW = AXI_ID_W - sel_w(NUM_PORTS);
  logic arready;
  logic [AXI_ID_W-1:0] arid;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0] arlen;
  logic arvalid;
  logic [AXI_ID_W-1:0] rid;
  logic [DATA_W-1:0] rdata;
  logic rlast;
  logic rvalid;
  logic rready;
  logic [NUM_PORTS*PW-1:0] rd_id;
  logic [NUM_PORTS*ADDR_W-1:0] rd_addr;
  logic [NUM_PORTS*LEN_W-1:0] rd_len;
  logic [NUM_PORTS-1:0] rd_info_valid;
  logic [NUM_PORTS-1:0] rd_info_rdy;
  logic [DATA_W-1:0] rd_data;
  logic [NUM_PORTS-1:0] rd_data_valid;
  logic [NUM_PORTS-1:0] rd_data_rdy;
  logic id_err;
  modport master (
    input arready, rid, rdata, rlast, rvalid, rd_id, rd_addr, rd_len, rd_info_valid, rd_data_rdy,
    output arid, araddr, arlen, arvalid, rready, rd_info_rdy, rd_data, rd_data_valid, id_err
  );
  modport slave (
    output arready, rid, rdata, rlast, rvalid, rd_id, rd_addr, rd_len, rd_info_valid, rd_data_rdy,
    input arid, araddr, arlen, arvalid, rready, rd_info_rdy, rd_data, rd_data_valid, id_err
  );
endinterface

// File: rtl/axi_rd_arbiter_n_rr_grant.sv
// rr_grant_n: round-robin picker, first requester after ptr (wrapping) wins
module rr_grant_n #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt = N'(1) << ((int'(ptr) + k) % N);
        idx = W'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/axi_rd_arbiter_n.sv
// axi_rd_arbiter_n: N-port AXI AR arbiter with per-port credits and R routing by rid tag
// AXI_ARB_STALL_CNT_EN adds stall_cnt, counting cycles AR is held off by arready.
module axi_rd_arbiter_n
  import axi_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORT_SEL_W = sel_w(NUM_PORTS),
  parameter int AXI_ID_W = 8,
  parameter int ADDR_W = 33,
  parameter int LEN_W = 8,
  parameter int DATA_W = 256,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic clk,
  input logic rst,
  axi_rd_arbiter_n_if.master bus
`ifdef AXI_ARB_STALL_CNT_EN
  , output logic [31:0] stall_cnt
`endif
);
  localparam int PW = AXI_ID_W - PORT_SEL_W;
  state_t state;
  logic [PORT_SEL_W-1:0] ptr, idx, t;
  logic [3:0] credit [NUM_PORTS];
  logic [NUM_PORTS-1:0] dec, elig, gnt;
  logic tag_ok, cap;
  assign t = PORT_SEL_W'(tag_of(32'(bus.rid), AXI_ID_W, PORT_SEL_W));
  assign tag_ok = int'(t) < NUM_PORTS;
  assign bus.rd_data = bus.rdata;
  assign bus.rd_data_valid = tag_ok ? NUM_PORTS'(bus.rvalid) << t : '0;
  assign bus.rready = tag_ok ? bus.rd_data_rdy[t] : 1'b1;
  // eligibility sees this cycle's rlast return so a freed credit is reusable at once
  always_comb begin
    dec = '0;
    elig = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      dec[p] = bus.rvalid & bus.rready & bus.rlast & tag_ok & (t == PORT_SEL_W'(p));
      elig[p] = bus.rd_info_valid[p] & ((credit[p] - 4'(dec[p])) < 4'(MAX_OUTSTANDING));
    end
  end
  rr_grant_n #(.N(NUM_PORTS), .W(PORT_SEL_W)) u_rr (.req(elig), .ptr(ptr), .gnt(gnt), .idx(idx));
  assign cap = (|elig) & ((state == IDLE) | bus.arready);
  assign bus.rd_info_rdy = cap ? gnt : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= PORT_SEL_W'(NUM_PORTS - 1);
      bus.arvalid <= 1'b0;
      bus.arid <= '0;
      bus.araddr <= '0;
      bus.arlen <= '0;
    end else if (cap) begin
      state <= ISSUE;
      ptr <= idx;
      bus.arvalid <= 1'b1;
      bus.arid <= {idx, bus.rd_id[int'(idx)*PW +: PW]};
      bus.araddr <= bus.rd_addr[int'(idx)*ADDR_W +: ADDR_W];
      bus.arlen <= bus.rd_len[int'(idx)*LEN_W +: LEN_W];
    end else if (state == ISSUE && bus.arready) begin
      state <= IDLE;
      bus.arvalid <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++)
      credit[p] <= rst ? 4'd0 : credit[p] + 4'(cap & gnt[p]) - 4'(dec[p]);
  end
  always_ff @(posedge clk) begin
    if (rst) bus.id_err <= 1'b0;
    else if (bus.rvalid & ~tag_ok) bus.id_err <= 1'b1;
  end
`ifdef AXI_ARB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (bus.arvalid & ~bus.arready & (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_axi_rd_arbiter_n.sv
// tb_axi_rd_arbiter_n: directed and random checks against a cycle-level reference model
module tb_axi_rd_arbiter_n;
  localparam int MAX = 4;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  axi_rd_arbiter_n_if #(.NUM_PORTS(4)) bus ();
  axi_rd_arbiter_n_if #(.NUM_PORTS(3)) bus3 ();
`ifdef AXI_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt, stall_cnt3;
`endif
  axi_rd_arbiter_n #(.NUM_PORTS(4)) dut (.clk(clk), .rst(rst), .bus(bus)
`ifdef AXI_ARB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  axi_rd_arbiter_n #(.NUM_PORTS(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3)
`ifdef AXI_ARB_STALL_CNT_EN
    , .stall_cnt(stall_cnt3)
`endif
  );
  int total = 0, bad = 0;
  int m_cred[4];
  int m_last;
  bit m_av;
  logic [7:0] m_id, m_len;
  logic [32:0] m_addr;
  int unsigned m_stall;
  int grants[$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_port(input int p, input logic [5:0] id, input logic [32:0] addr, input logic [7:0] len);
    bus.rd_id[p*6 +: 6] = id;
    bus.rd_addr[p*33 +: 33] = addr;
    bus.rd_len[p*8 +: 8] = len;
  endtask

  task automatic idle_inputs();
    bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rlast = 0; bus.rvalid = 0;
    bus.rd_info_valid = 0; bus.rd_data_rdy = 0;
    bus3.arready = 0; bus3.rid = 0; bus3.rdata = 0; bus3.rlast = 0; bus3.rvalid = 0;
    bus3.rd_info_valid = 0; bus3.rd_data_rdy = 0; bus3.rd_id = 0; bus3.rd_addr = 0; bus3.rd_len = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    foreach (m_cred[i]) m_cred[i] = 0;
    m_last = 3; m_av = 0; m_id = 0; m_addr = 0; m_len = 0; m_stall = 0;
    grants.delete();
  endtask

  // model: predict outputs for the current inputs, then advance one clock
  task automatic step();
    int t, w, p, dp;
    bit hs_r, cap_ok, ar_hs, stall;
    #1;
    t = int'(bus.rid[7:6]);
    check("rd_data_valid", bus.rd_data_valid, bus.rvalid ? 4'(1 << t) : 4'd0);
    check("rready", bus.rready, bus.rd_data_rdy[t]);
    check("rd_data", bus.rd_data, bus.rdata);
    hs_r = bus.rvalid && bus.rd_data_rdy[t] && bus.rlast;
    cap_ok = !m_av || bus.arready;
    w = -1;
    for (int k = 1; k <= 4; k++) begin
      p = (m_last + k) % 4;
      dp = (hs_r && t == p) ? 1 : 0;
      if (w < 0 && cap_ok && bus.rd_info_valid[p] && (m_cred[p] - dp) < MAX) w = p;
    end
    check("info_rdy", bus.rd_info_rdy, w >= 0 ? 4'(1 << w) : 4'd0);
    check("arvalid", bus.arvalid, m_av);
    if (m_av) begin
      check("arid", bus.arid, m_id);
      check("araddr", bus.araddr, m_addr);
      check("arlen", bus.arlen, m_len);
    end
`ifdef AXI_ARB_STALL_CNT_EN
    check("stall_cnt", stall_cnt, m_stall);
`endif
    ar_hs = m_av && bus.arready;
    stall = m_av && !bus.arready;
    @(posedge clk);
    if (hs_r) m_cred[t]--;
    if (w >= 0) begin
      m_cred[w]++;
      m_last = w;
      m_av = 1;
      m_id = {2'(w), bus.rd_id[w*6 +: 6]};
      m_addr = bus.rd_addr[w*33 +: 33];
      m_len = bus.rd_len[w*8 +: 8];
      grants.push_back(w);
    end else if (ar_hs) m_av = 0;
    if (stall && m_stall != 32'hFFFF_FFFF) m_stall++;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] held;
    for (int p = 0; p < 4; p++) set_port(p, 6'(p + 8), 33'(32'h100 * (p + 1)), 8'(p + 1));
    do_reset();
    #1;
    check("rst_arvalid", bus.arvalid, 0);
    check("rst_arid", bus.arid, 0);
    check("rst_araddr", bus.araddr, 0);
    check("rst_arlen", bus.arlen, 0);
    check("rst_info_rdy", bus.rd_info_rdy, 0);
    check("rst_id_err", bus.id_err, 0);
`ifdef AXI_ARB_STALL_CNT_EN
    check("rst_stall", stall_cnt, 0);
`endif
    @(negedge clk);
    // single request on port 2
    set_port(2, 6'd5, 33'h1000, 8'd7);
    bus.rd_info_valid = 4'b0100; bus.arready = 1;
    #1 check("single_rdy", bus.rd_info_rdy, 4'b0100);
    step();
    bus.rd_info_valid = 0;
    check("single_arvalid", bus.arvalid, 1);
    check("single_arid", bus.arid, 8'h85);
    check("single_araddr", bus.araddr, 33'h1000);
    check("single_arlen", bus.arlen, 8'd7);
    repeat (3) step();
    // fairness
    do_reset();
    bus.rd_info_valid = 4'b1111; bus.arready = 1;
    repeat (12) step();
    check("fair_count", grants.size(), 12);
    foreach (grants[i]) check($sformatf("fair_%0d", i), grants[i], i % 4);
    // credit limit on port 0
    do_reset();
    bus.rd_info_valid = 4'b0001; bus.arready = 1;
    repeat (8) step();
    check("credit_cap", grants.size(), 4);
    bus.rvalid = 1; bus.rlast = 1; bus.rid = 8'h03; bus.rd_data_rdy = 4'b0001;
    step();
    bus.rvalid = 0; bus.rlast = 0;
    check("credit_return_arvalid", bus.arvalid, 1);
    repeat (4) step();
    check("credit_fifth", grants.size(), 5);
    // arready backpressure
    do_reset();
    bus.rd_info_valid = 4'b1111; bus.arready = 0;
    step();
    held = bus.arid;
    repeat (10) step();
    check("bp_grants", grants.size(), 1);
    check("bp_arid_held", bus.arid, held);
`ifdef AXI_ARB_STALL_CNT_EN
    check("bp_stall10", stall_cnt, 10);
`endif
    bus.arready = 1;
    repeat (3) step();
    // R routing, tag 3
    bus.rd_info_valid = 0;
    bus.rvalid = 1; bus.rlast = 0; bus.rid = 8'hC7; bus.rd_data_rdy = 4'b1000;
    bus.rdata = {8{32'hA5A5_0001}};
    #1;
    check("route_valid", bus.rd_data_valid, 4'b1000);
    check("route_rready", bus.rready, 1);
    step();
    bus.rvalid = 0;
    // simultaneous capture and rlast on port 1
    do_reset();
    bus.rd_info_valid = 4'b0010; bus.arready = 1;
    repeat (4) step();
    bus.rvalid = 1; bus.rlast = 1; bus.rid = 8'h41; bus.rd_data_rdy = 4'b0010;
    step();
    bus.rvalid = 0; bus.rlast = 0;
    check("simul_grant", grants.size(), 5);
    repeat (3) step();
    check("simul_held", grants.size(), 5);
    // invalid tag on the 3-port instance
    bus3.rvalid = 1; bus3.rid = 8'hC0; bus3.rd_data_rdy = 3'b000;
    #1;
    check("bad_tag_rready", bus3.rready, 1);
    check("bad_tag_valid", bus3.rd_data_valid, 0);
    @(negedge clk);
    check("bad_tag_err", bus3.id_err, 1);
    bus3.rid = 8'h80; bus3.rd_data_rdy = 3'b100;
    #1;
    check("tag2_valid", bus3.rd_data_valid, 3'b100);
    check("tag2_rready", bus3.rready, 1);
    bus3.rvalid = 0;
    repeat (3) @(negedge clk);
    check("err_sticky", bus3.id_err, 1);
    // random traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      int p;
      p = $urandom_range(0, 3);
      bus.rd_info_valid = 4'($urandom);
      bus.arready = ($urandom % 4) != 0;
      bus.rd_data_rdy = 4'($urandom);
      bus.rdata = {8{$urandom}};
      bus.rvalid = m_cred[p] > 0 && ($urandom % 2 == 1);
      bus.rid = {2'(p), 6'($urandom)};
      bus.rlast = $urandom % 2 == 1;
      for (int q = 0; q < 4; q++) set_port(q, 6'($urandom), {1'b0, $urandom}, 8'($urandom));
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
